ahb_master_port: RTL and testbench

Single-outstanding AHB-Lite master front end that sits directly upstream of the three-master HREADY switch. One instance per master (CPU, CoreSystem, Other): it buffers client transfer requests in a small FIFO, announces each transfer to the switch with a one-cycle NONSEQ, and waits for the switch's HREADY grant. It then holds address/control/write data until the slave signals completion, and returns read data and error status to the client.

---
 rtl/ahb_master_port.sv | 119 +++++++++++
 tb/tb_ahb_master_port.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_port.sv
// AHB-Lite single-outstanding master front end feeding the HREADY switch.
// Client req_* -> FIFO -> NONSEQ/HADDR/HWRITE/HWDATA; completion -> rsp_*.
module ahb_master_port #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        HTRANS,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              slave_done,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HRESP
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + ADDR_W + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DATA,
    S_RESP
  } state_t;

  state_t state, state_nx;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, empty;
  logic          done_now;
  logic [EW-1:0] head;

  assign req_ready = (count < CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = req_valid && req_ready;
  assign pop       = (state == S_IDLE) && !empty;
  assign head      = mem[rd_ptr];

  // Completion is only honoured once the switch has granted us.
  assign done_now = slave_done &&
    ((state == S_DATA) || ((state == S_WAIT) && HREADY));

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= {req_write, req_addr, req_wdata};
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (!empty) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (HREADY && slave_done) state_nx = S_RESP;
        else if (HREADY)          state_nx = S_DATA;
      end
      S_DATA:  if (slave_done) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign HTRANS    = (state == S_ISSUE) ? 2'b10 : 2'b00;
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (pop) begin
        HWRITE <= head[EW-1];
        HADDR  <= head[ADDR_W+DATA_W-1:DATA_W];
        HWDATA <= head[DATA_W-1:0];
      end
      if (done_now) begin
        rsp_rdata <= HWRITE ? '0 : HRDATA;
        rsp_err   <= HRESP;
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_port.sv
// Directed bench for ahb_master_port.
// One task per scenario, inline comparisons, single summary line.
module tb_ahb_master_port;

  logic        HCLK = 0;
  logic        HRESETn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE, HREADY, slave_done, HRESP;

  int checks = 0;
  int failures = 0;

  ahb_master_port #(.FIFO_DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY),
    .slave_done(slave_done), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic push(input logic w, input logic [31:0] a,
                      input logic [31:0] d);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    tick;
    req_valid = 0;
  endtask

  task automatic test_reset;
    checks++;
    if (req_ready !== 1'b1 || HTRANS !== 2'b00 || HADDR !== 0 ||
        HWDATA !== 0 || HWRITE !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_rdata !== 0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_vals got rdy=%b tr=%b a=%h d=%h w=%b v=%b r=%h e=%b want 1 00 0 0 0 0 0 0",
               req_ready, HTRANS, HADDR, HWDATA, HWRITE, rsp_valid,
               rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_read;
    push(0, 32'h0000_1000, 0);
    checks++;
    if (HTRANS !== 2'b00) begin
      failures++;
      $display("FAIL read_idle_first got %b want 00", HTRANS);
    end
    tick;
    checks++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h1000 || HWRITE !== 0) begin
      failures++;
      $display("FAIL read_issue got tr=%b a=%h w=%b want 10 1000 0",
               HTRANS, HADDR, HWRITE);
    end
    tick;
    checks++;
    if (HTRANS !== 2'b00) begin
      failures++;
      $display("FAIL read_nonseq_len got %b want 00", HTRANS);
    end
    HREADY = 1;
    tick;
    HREADY = 0;
    checks++;
    if (rsp_valid !== 0) begin
      failures++;
      $display("FAIL read_early_rsp got %b want 0", rsp_valid);
    end
    slave_done = 1; HRDATA = 32'hDEAD_BEEF;
    tick;
    slave_done = 0; HRDATA = 0;
    checks++;
    if (rsp_valid !== 1 || rsp_rdata !== 32'hDEAD_BEEF ||
        rsp_err !== 0) begin
      failures++;
      $display("FAIL read_rsp got v=%b d=%h e=%b want 1 deadbeef 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    tick;
    checks++;
    if (rsp_valid !== 0) begin
      failures++;
      $display("FAIL read_pulse_len got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_write_delay;
    push(1, 32'h20, 32'h1234_5678);
    tick;
    checks++;
    if (HTRANS !== 2'b10 || HWRITE !== 1) begin
      failures++;
      $display("FAIL wr_issue got tr=%b w=%b want 10 1", HTRANS, HWRITE);
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++;
      if (HTRANS !== 2'b00 || HADDR !== 32'h20 ||
          HWDATA !== 32'h1234_5678 || rsp_valid !== 0) begin
        failures++;
        $display("FAIL wr_hold%0d got tr=%b a=%h d=%h v=%b want 00 20 12345678 0",
                 i, HTRANS, HADDR, HWDATA, rsp_valid);
      end
    end
    HREADY = 1;
    tick;
    HREADY = 0; slave_done = 1; HRDATA = 32'hFFFF_FFFF;
    tick;
    slave_done = 0; HRDATA = 0;
    checks++;
    if (rsp_valid !== 1 || rsp_rdata !== 0 || rsp_err !== 0) begin
      failures++;
      $display("FAIL wr_rsp got v=%b d=%h e=%b want 1 0 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    tick;
    checks++;
    if (rsp_valid !== 0 || HADDR !== 32'h20) begin
      failures++;
      $display("FAIL wr_after got v=%b a=%h want 0 20", rsp_valid, HADDR);
    end
  endtask

  task automatic test_min_latency;
    int lat = -1;
    int pulses = 0;
    HREADY = 1; slave_done = 1; HRDATA = 32'h0000_A5A5;
    push(0, 32'h44, 0);
    for (int i = 1; i <= 6; i++) begin
      tick;
      if (rsp_valid === 1'b1) begin
        pulses++;
        if (lat < 0) lat = i;
      end
    end
    HREADY = 0; slave_done = 0; HRDATA = 0;
    checks++;
    if (lat != 3 || pulses != 1) begin
      failures++;
      $display("FAIL min_latency got lat=%0d pulses=%0d want 3 1",
               lat, pulses);
    end
    checks++;
    if (rsp_rdata !== 32'h0000_A5A5) begin
      failures++;
      $display("FAIL min_lat_data got %h want 0000a5a5", rsp_rdata);
    end
  endtask

  task automatic test_err;
    push(0, 32'h80, 0);
    tick;
    tick;
    HREADY = 1; slave_done = 1; HRESP = 1;
    tick;
    HREADY = 0; slave_done = 0; HRESP = 0;
    checks++;
    if (rsp_valid !== 1 || rsp_err !== 1) begin
      failures++;
      $display("FAIL err_rsp got v=%b e=%b want 1 1", rsp_valid, rsp_err);
    end
    tick;
    slave_done = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (rsp_valid !== 0 || HTRANS !== 2'b00) begin
        failures++;
        $display("FAIL spurious_done%0d got v=%b tr=%b want 0 00",
                 i, rsp_valid, HTRANS);
      end
    end
    slave_done = 0;
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    bit hit;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (req_ready !== 1) begin
        failures++;
        $display("FAIL full_rdy%0d got %b want 1", i, req_ready);
      end
      push(0, 32'h100 + 32'(i * 4), 0);
    end
    checks++;
    if (req_ready !== 0) begin
      failures++;
      $display("FAIL full_flag got %b want 0", req_ready);
    end
    req_valid = 1; req_addr = 32'h1FF;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (req_ready !== 0) begin
        failures++;
        $display("FAIL full_stall%0d got %b want 0", i, req_ready);
      end
    end
    req_valid = 0;
    checks++;
    if (HTRANS !== 2'b00 || HADDR !== 32'h100) begin
      failures++;
      $display("FAIL full_head got tr=%b a=%h want 00 100", HTRANS, HADDR);
    end
    HREADY = 1; slave_done = 1;
    tick;
    HREADY = 0; slave_done = 0;
    if (rsp_valid === 1'b1) pulses++;
    for (int k = 1; k < 5; k++) begin
      hit = 0;
      for (int t = 0; t < 6 && !hit; t++) begin
        tick;
        if (HTRANS === 2'b10) hit = 1;
      end
      checks++;
      if (!hit || HADDR !== 32'h100 + 32'(k * 4)) begin
        failures++;
        $display("FAIL order%0d got issued=%0d a=%h want 1 %h",
                 k, hit, HADDR, 32'h100 + 32'(k * 4));
      end
      tick;
      HREADY = 1; slave_done = 1;
      tick;
      HREADY = 0; slave_done = 0;
      if (rsp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 5 || req_ready !== 1) begin
      failures++;
      $display("FAIL drain got pulses=%0d rdy=%b want 5 1",
               pulses, req_ready);
    end
    hit = 0;
    for (int t = 0; t < 4; t++) begin
      tick;
      if (HTRANS === 2'b10) hit = 1;
    end
    checks++;
    if (hit) begin
      failures++;
      $display("FAIL stalled_req got issued=1 want 0");
    end
  endtask

  task automatic test_reset_mid;
    push(1, 32'h300, 32'hCAFE_0000);
    tick;
    tick;
    HREADY = 1;
    tick;
    HREADY = 0;
    #2;
    HRESETn = 0;
    #1;
    checks++;
    if (HTRANS !== 2'b00 || HADDR !== 0 || HWDATA !== 0 ||
        HWRITE !== 0 || rsp_valid !== 0 || req_ready !== 1) begin
      failures++;
      $display("FAIL async_rst got tr=%b a=%h d=%h w=%b v=%b rdy=%b want 00 0 0 0 0 1",
               HTRANS, HADDR, HWDATA, HWRITE, rsp_valid, req_ready);
    end
    tick;
    tick;
    HRESETn = 1;
    slave_done = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (rsp_valid !== 0 || HTRANS !== 2'b00 || req_ready !== 1) begin
        failures++;
        $display("FAIL post_rst%0d got v=%b tr=%b rdy=%b want 0 00 1",
                 i, rsp_valid, HTRANS, req_ready);
      end
    end
    slave_done = 0;
  endtask

  initial begin
    HRESETn = 0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    HREADY = 0; slave_done = 0; HRDATA = 0; HRESP = 0;
    tick;
    tick;
    test_reset;
    HRESETn = 1;
    tick;
    test_reset;
    test_read;
    test_write_delay;
    test_min_latency;
    test_err;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
